// File: rtl/iterative_right_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : iterative_right_shifter_pkg
// Description : Shared ALU definitions for the iterative right shifter:
//               state encoding, datapath constants and shift-op select.
// Revision    : 1.0 - initial release
// ============================================================================
package iterative_right_shifter_pkg;

  localparam int RS_WIDTH   = 32;
  localparam int RS_NSTAGES = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } rs_state_t;

  typedef enum logic {
    OP_SRL = 1'b0,
    OP_SRA = 1'b1
  } rs_op_t;

endpackage : iterative_right_shifter_pkg
`default_nettype wire

// File: rtl/iterative_right_shifter_stage.sv
`default_nettype none
// ============================================================================
// Module      : right_shift_stage
// Description : Combinational single stage: shifts the value right by 2^idx,
//               filling the vacated upper bits with the fill bit.
// Revision    : 1.0 - initial release
// ============================================================================
module right_shift_stage
  import iterative_right_shifter_pkg::*;
(
  input  logic [RS_WIDTH-1:0] i_value,
  input  logic [2:0]          i_idx,
  input  logic                i_fill,
  output logic [RS_WIDTH-1:0] o_value
);

  // Select one of the five power-of-two shift distances.
  always_comb begin
    o_value = i_value;
    case (i_idx)
      3'd0: o_value = {{1{i_fill}},  i_value[RS_WIDTH-1:1]};
      3'd1: o_value = {{2{i_fill}},  i_value[RS_WIDTH-1:2]};
      3'd2: o_value = {{4{i_fill}},  i_value[RS_WIDTH-1:4]};
      3'd3: o_value = {{8{i_fill}},  i_value[RS_WIDTH-1:8]};
      3'd4: o_value = {{16{i_fill}}, i_value[RS_WIDTH-1:16]};
      default: o_value = i_value;
    endcase
  end

endmodule : right_shift_stage
`default_nettype wire

// File: rtl/iterative_right_shifter.sv
`default_nettype none
// ============================================================================
// Module      : iterative_right_shifter
// Description : Multi-cycle 32-bit SRL/SRA. One binary stage (16,8,4,2,1) is
//               resolved per cycle on a single working register; operation
//               is requested and returned over a start/ready/valid handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module iterative_right_shifter
  import iterative_right_shifter_pkg::*;
#(
  parameter int WIDTH   = RS_WIDTH,
  parameter int NSTAGES = RS_NSTAGES
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             ctrl_start,
  input  logic [WIDTH-1:0] data,
  input  logic [4:0]       shamt,
  input  logic             arith,
  output logic             ready,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result
);

  rs_state_t        r_state;
  rs_state_t        w_state_next;
  logic [WIDTH-1:0] r_work;
  logic [4:0]       r_amt;
  logic             r_fill;
  logic [2:0]       r_idx;
  logic [WIDTH-1:0] r_result;

  logic             w_accept;
  logic             w_last_stage;
  logic [WIDTH-1:0] w_stage_out;
  logic [WIDTH-1:0] w_work_next;

  // Shift distance depends on the current stage; the stage is applied only
  // when the matching bit of the captured amount is set.
  right_shift_stage u_stage (
    .i_value (r_work),
    .i_idx   (r_idx),
    .i_fill  (r_fill),
    .o_value (w_stage_out)
  );

  assign w_accept     = ctrl_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_stage = (r_state == ST_SHIFT) && (r_idx == 3'd0);
  assign w_work_next  = r_amt[r_idx] ? w_stage_out : r_work;

  // State register.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    ready        = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (ctrl_start) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (r_idx == 3'd0) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        ready        = 1'b1;
        result_valid = 1'b1;
        w_state_next = ctrl_start ? ST_SHIFT : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operand capture on accept, then one stage per cycle from idx 4 down to 0.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_work <= '0;
      r_amt  <= '0;
      r_fill <= 1'b0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_work <= data;
      r_amt  <= shamt;
      r_fill <= arith & data[WIDTH-1];
      r_idx  <= 3'(NSTAGES - 1);
    end else if (r_state == ST_SHIFT) begin
      r_work <= w_work_next;
      r_idx  <= r_idx - 3'd1;
    end
  end

  // Result is loaded only as the last stage completes and is held otherwise.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_result <= '0;
    end else if (w_last_stage) begin
      r_result <= w_work_next;
    end
  end

  assign result = r_result;

endmodule : iterative_right_shifter
`default_nettype wire

// File: tb/tb_iterative_right_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_iterative_right_shifter
// Description : Directed self-checking bench for iterative_right_shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iterative_right_shifter;

  logic        clock;
  logic        ctrl_reset_n;
  logic        ctrl_start;
  logic [31:0] data;
  logic [4:0]  shamt;
  logic        arith;
  logic        ready;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;

  iterative_right_shifter dut (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .ctrl_start   (ctrl_start),
    .data         (data),
    .shamt        (shamt),
    .arith        (arith),
    .ready        (ready),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and follow it through SHIFT and DONE.
  // With mangle set, operands change and a stray start pulse is driven mid-flight.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                        input logic [31:0] exp, input string tag, input bit mangle);
    data = d; shamt = s; arith = a; ctrl_start = 1'b1;
    @(negedge clock);
    ctrl_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk({tag, "_busy"},  {31'd0, busy},         32'd1);
      chk({tag, "_vld0"},  {31'd0, result_valid}, 32'd0);
      chk({tag, "_rdy0"},  {31'd0, ready},        32'd0);
      if (mangle && i == 1) begin data = 32'h0; shamt = ~s; arith = ~a; end
      if (mangle && i == 2) begin ctrl_start = 1'b1; data = 32'h0F0F0F0F; end
      if (mangle && i == 3) ctrl_start = 1'b0;
      @(negedge clock);
    end
    chk({tag, "_valid"},  {31'd0, result_valid}, 32'd1);
    chk({tag, "_result"}, result,                 exp);
    chk({tag, "_ready"},  {31'd0, ready},         32'd1);
    chk({tag, "_nbusy"},  {31'd0, busy},          32'd0);
    @(negedge clock);
    chk({tag, "_pulse"},  {31'd0, result_valid}, 32'd0);
    chk({tag, "_idle"},   {31'd0, ready},         32'd1);
    chk({tag, "_hold"},   result,                 exp);
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    ctrl_start   = 1'b0;
    data         = 32'h0;
    shamt        = 5'd0;
    arith        = 1'b0;
    #2;
    chk("rst_ready",  {31'd0, ready},        32'd1);
    chk("rst_busy",   {31'd0, busy},         32'd0);
    chk("rst_valid",  {31'd0, result_valid}, 32'd0);
    chk("rst_result", result,                32'd0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    @(negedge clock);

    // Directed vectors.
    run_op(32'h12345678, 5'd8,  1'b0, 32'h00123456, "srl8",   1'b0);
    run_op(32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, "sra31",  1'b0);
    run_op(32'h80000000, 5'd31, 1'b0, 32'h00000001, "srl31",  1'b0);
    run_op(32'h87654321, 5'd4,  1'b1, 32'hF8765432, "sra4",   1'b0);
    run_op(32'h87654321, 5'd13, 1'b0, 32'h00043B2A, "srl13",  1'b0);
    run_op(32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000, "sra_pos",1'b0);
    run_op(32'hDEADBEEF, 5'd0,  1'b1, 32'hDEADBEEF, "zero",   1'b1);
    run_op(32'h00FF00FF, 5'd7,  1'b1, 32'h0001FE01, "ignore", 1'b1);

    // Back-to-back: start held high through DONE.
    data = 32'h12345678; shamt = 5'd8; arith = 1'b0; ctrl_start = 1'b1;
    @(negedge clock);
    data = 32'hF0000000; shamt = 5'd4; arith = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("b2b_busy1", {31'd0, busy}, 32'd1);
      @(negedge clock);
    end
    chk("b2b_valid1",  {31'd0, result_valid}, 32'd1);
    chk("b2b_result1", result,                32'h00123456);
    @(negedge clock);
    ctrl_start = 1'b0;
    chk("b2b_noidle", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("b2b_vld0", {31'd0, result_valid}, 32'd0);
      @(negedge clock);
    end
    chk("b2b_valid2",  {31'd0, result_valid}, 32'd1);
    chk("b2b_result2", result,                32'hFF000000);
    @(negedge clock);

    // Asynchronous reset in the third SHIFT cycle.
    data = 32'hA5A5A5A5; shamt = 5'd3; arith = 1'b0; ctrl_start = 1'b1;
    @(negedge clock);
    ctrl_start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 ctrl_reset_n = 1'b0;
    #1;
    chk("mid_rst_busy",   {31'd0, busy},         32'd0);
    chk("mid_rst_ready",  {31'd0, ready},        32'd1);
    chk("mid_rst_result", result,                32'd0);
    chk("mid_rst_valid",  {31'd0, result_valid}, 32'd0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    @(negedge clock);
    run_op(32'hA5A5A5A5, 5'd3, 1'b1, 32'hF4B4B4B4, "post_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_iterative_right_shifter
`default_nettype wire
